// File: rtl/axi_lite_rd_arbiter_if.sv
// rtl/axi_lite_rd_arbiter_if.sv - AXI-lite read-channel bundle with N parallel AR/R lanes and shared R payload
interface axi_lite_rd_arbiter_if #(
   parameter int N          = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic [N-1:0]            ARVALID;
   logic [N-1:0]            ARREADY;
   logic [N*ADDR_WIDTH-1:0] ARADDR;
   logic [N-1:0]            RVALID;
   logic [N-1:0]            RREADY;
   logic [DATA_WIDTH-1:0]   RDATA;
   logic [1:0]              RRESP;

   modport master (
      output ARVALID, ARADDR, RREADY,
      input  ARREADY, RVALID, RDATA, RRESP
   );

   modport slave (
      input  ARVALID, ARADDR, RREADY,
      output ARREADY, RVALID, RDATA, RRESP
   );
endinterface

// File: rtl/axi_lite_rd_arbiter.sv
// rtl/axi_lite_rd_arbiter.sv - round-robin arbiter sharing one AXI-lite read slave among M masters
// Optional macro AXI_LITE_RD_ARB_PRIO_EN gives master 0 fixed highest priority.
module axi_lite_rd_arbiter #(
   parameter int M          = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst,
   axi_lite_rd_arbiter_if.slave   s_axi,
   axi_lite_rd_arbiter_if.master  m_axi
);
   localparam int PW = (M > 1) ? $clog2(M) : 1;
   localparam logic [M-1:0] ONE_HOT0 = {{(M-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

   state_t                r_state;
   logic [PW-1:0]         r_gnt;
   logic [PW-1:0]         r_ptr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp;
   logic                  r_m_arvalid;
   logic                  r_m_rready;
   logic [M-1:0]          r_s_rvalid;

   logic                  w_any;
   logic [PW-1:0]         w_win;
   logic [PW-1:0]         w_ptr_next;

`ifdef AXI_LITE_RD_ARB_PRIO_EN
   // Round-robin ring covers masters 1..M-1 only; a zero pointer starts at 1.
   function automatic logic [PW-1:0] f_slot(input logic [PW-1:0] base, input int k);
      int start;
      start = (base == '0) ? 1 : int'(base);
      return PW'(1 + ((start - 1 + k) % (M - 1)));
   endfunction

   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int k = M - 2; k >= 0; k--) begin
         if (s_axi.ARVALID[f_slot(r_ptr, k)]) begin
            w_any = 1'b1;
            w_win = f_slot(r_ptr, k);
         end
      end
      if (s_axi.ARVALID[0]) begin
         w_any = 1'b1;
         w_win = '0;
      end
   end

   always_comb begin
      w_ptr_next = r_ptr;
      if (r_gnt != '0) begin
         w_ptr_next = (r_gnt == PW'(M - 1)) ? PW'(1) : r_gnt + PW'(1);
      end
   end
`else
   function automatic logic [PW-1:0] f_slot(input logic [PW-1:0] base, input int k);
      return PW'((int'(base) + k) % M);
   endfunction

   // Scan backwards so the earliest requester in cyclic order is the last to win.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int k = M - 1; k >= 0; k--) begin
         if (s_axi.ARVALID[f_slot(r_ptr, k)]) begin
            w_any = 1'b1;
            w_win = f_slot(r_ptr, k);
         end
      end
   end

   always_comb begin
      w_ptr_next = (r_gnt == PW'(M - 1)) ? '0 : r_gnt + PW'(1);
   end
`endif

   // Grant is combinational so the master sees ARREADY in its request cycle.
   assign s_axi.ARREADY = (!ap_rst && r_state == ST_IDLE && w_any) ? (ONE_HOT0 << w_win) : '0;
   assign s_axi.RVALID  = r_s_rvalid;
   assign s_axi.RDATA   = r_rdata;
   assign s_axi.RRESP   = r_rresp;

   assign m_axi.ARVALID = r_m_arvalid;
   assign m_axi.ARADDR  = r_addr;
   assign m_axi.RREADY  = r_m_rready;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_gnt       <= '0;
         r_m_arvalid <= 1'b0;
         r_m_rready  <= 1'b0;
         r_s_rvalid  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_addr      <= s_axi.ARADDR[w_win*ADDR_WIDTH +: ADDR_WIDTH];
                  r_gnt       <= w_win;
                  r_m_arvalid <= 1'b1;
                  r_state     <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (m_axi.ARREADY[0]) begin
                  r_m_arvalid <= 1'b0;
                  r_m_rready  <= 1'b1;
                  r_state     <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (m_axi.RVALID[0]) begin
                  r_rdata    <= m_axi.RDATA;
                  r_rresp    <= m_axi.RRESP;
                  r_m_rready <= 1'b0;
                  r_s_rvalid <= ONE_HOT0 << r_gnt;
                  r_state    <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (s_axi.RREADY[r_gnt]) begin
                  r_s_rvalid <= '0;
                  r_ptr      <= w_ptr_next;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// tb/tb_axi_lite_rd_arbiter.sv - directed self-checking bench for axi_lite_rd_arbiter
module tb_axi_lite_rd_arbiter;
`ifdef AXI_LITE_RD_ARB_PRIO_EN
   localparam int M = 3;
`else
   localparam int M = 2;
`endif
   localparam int AW = 8;
   localparam int DW = 32;

   logic ap_clk = 1'b0;
   logic ap_rst;
   int   vectors = 0;
   int   miscompares = 0;
   int   rcnt[M];

   axi_lite_rd_arbiter_if #(.N(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_axi ();
   axi_lite_rd_arbiter_if #(.N(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axi ();

   axi_lite_rd_arbiter #(.M(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .s_axi  (s_axi),
      .m_axi  (m_axi)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic cyc;
      @(posedge ap_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete transaction; masters request 'req', master i's address is (i+1)*16.
   task automatic xact(input logic [M-1:0] req, input logic [M-1:0] exp_gnt,
                       input logic [31:0] data, input logic [1:0] resp);
      logic [AW-1:0] exp_addr;
      exp_addr = '0;
      for (int i = 0; i < M; i++) if (exp_gnt[i]) exp_addr = AW'((i + 1) * 16);
      cyc;
      s_axi.ARVALID = req; s_axi.RREADY = '1;
      m_axi.ARREADY = 1'b0; m_axi.RVALID = 1'b0;
      @(negedge ap_clk);
      chk("xact_arready", 64'(s_axi.ARREADY), 64'(exp_gnt));
      cyc;
      m_axi.ARREADY = 1'b1;
      @(negedge ap_clk);
      chk("xact_m_araddr", 64'(m_axi.ARADDR), 64'(exp_addr));
      cyc;
      m_axi.ARREADY = 1'b0; m_axi.RVALID = 1'b1; m_axi.RDATA = data; m_axi.RRESP = resp;
      @(negedge ap_clk);
      chk("xact_arready_busy", 64'(s_axi.ARREADY), 64'd0);
      cyc;
      m_axi.RVALID = 1'b0;
      @(negedge ap_clk);
      chk("xact_s_rvalid", 64'(s_axi.RVALID), 64'(exp_gnt));
      chk("xact_s_rdata", 64'(s_axi.RDATA), 64'(data));
      chk("xact_s_rresp", 64'(s_axi.RRESP), 64'(resp));
      for (int i = 0; i < M; i++) if (s_axi.RVALID[i]) rcnt[i]++;
   endtask

   initial begin
      for (int i = 0; i < M; i++) rcnt[i] = 0;
      ap_rst = 1'b1;
      s_axi.ARVALID = '1; s_axi.ARADDR = '0; s_axi.RREADY = '0;
      m_axi.ARREADY = 1'b0; m_axi.RVALID = 1'b0; m_axi.RDATA = '0; m_axi.RRESP = '0;
      cyc; cyc;
      @(negedge ap_clk);
      chk("rst_s_arready", 64'(s_axi.ARREADY), 64'd0);
      chk("rst_s_rvalid", 64'(s_axi.RVALID), 64'd0);
      chk("rst_m_arvalid", 64'(m_axi.ARVALID), 64'd0);
      chk("rst_m_rready", 64'(m_axi.RREADY), 64'd0);

`ifdef AXI_LITE_RD_ARB_PRIO_EN
      ap_rst = 1'b0;
      s_axi.ARVALID = '0;
      s_axi.ARADDR = {8'h30, 8'h20, 8'h10};
      xact(3'b111, 3'b001, 32'hA0000000, 2'b00);
      xact(3'b111, 3'b001, 32'hA0000001, 2'b00);
      xact(3'b111, 3'b001, 32'hA0000002, 2'b00);
      xact(3'b110, 3'b010, 32'hA0000003, 2'b00);
      xact(3'b110, 3'b100, 32'hA0000004, 2'b00);
      xact(3'b110, 3'b010, 32'hA0000005, 2'b11);
      xact(3'b111, 3'b001, 32'hA0000006, 2'b00);
`else
      // Single master 1 read of 0x04
      cyc;
      ap_rst = 1'b0; s_axi.ARVALID = 2'b10; s_axi.ARADDR = 16'h0400;
      @(negedge ap_clk);
      chk("t1_arready", 64'(s_axi.ARREADY), 64'h2);
      cyc;
      s_axi.ARVALID = 2'b00; m_axi.ARREADY = 1'b1;
      @(negedge ap_clk);
      chk("t1_m_arvalid", 64'(m_axi.ARVALID), 64'h1);
      chk("t1_m_araddr", 64'(m_axi.ARADDR), 64'h04);
      cyc;
      m_axi.ARREADY = 1'b0; m_axi.RVALID = 1'b1; m_axi.RDATA = 32'hDEADBEEF; m_axi.RRESP = 2'b00;
      s_axi.RREADY = 2'b10;
      @(negedge ap_clk);
      chk("t1_m_rready", 64'(m_axi.RREADY), 64'h1);
      chk("t1_s_rvalid_early", 64'(s_axi.RVALID), 64'h0);
      cyc;
      m_axi.RVALID = 1'b0;
      @(negedge ap_clk);
      chk("t1_s_rvalid", 64'(s_axi.RVALID), 64'h2);
      chk("t1_s_rdata", 64'(s_axi.RDATA), 64'hDEADBEEF);
      chk("t1_s_rresp", 64'(s_axi.RRESP), 64'h0);
      cyc;
      s_axi.RREADY = 2'b00;
      @(negedge ap_clk);
      chk("t1_s_rvalid_done", 64'(s_axi.RVALID), 64'h0);

      // Both masters request continuously: grants alternate 0,1,0,1
      s_axi.ARADDR = {8'h20, 8'h10};
      for (int k = 0; k < 4; k++) begin
         logic [M-1:0] eg;
         eg = (k % 2 == 0) ? 2'b01 : 2'b10;
         xact(2'b11, eg, 32'h10000000 + 32'(k), (k == 3) ? 2'b11 : 2'b00);
      end
      chk("t2_count_m0", 64'(rcnt[0]), 64'd2);
      chk("t2_count_m1", 64'(rcnt[1]), 64'd2);

      // Master 0 stalls RREADY for 5 cycles; master 1 asserts RREADY and ARVALID meanwhile
      cyc;
      s_axi.RREADY = 2'b00; s_axi.ARVALID = 2'b01; s_axi.ARADDR = {8'h20, 8'h30};
      @(negedge ap_clk);
      chk("t3_arready", 64'(s_axi.ARREADY), 64'h1);
      cyc;
      s_axi.ARVALID = 2'b10; m_axi.ARREADY = 1'b1;
      @(negedge ap_clk);
      chk("t3_m_araddr", 64'(m_axi.ARADDR), 64'h30);
      chk("t3_arready_busy", 64'(s_axi.ARREADY), 64'h0);
      cyc;
      m_axi.ARREADY = 1'b0; m_axi.RVALID = 1'b1; m_axi.RDATA = 32'hCAFEF00D; m_axi.RRESP = 2'b00;
      @(negedge ap_clk);
      for (int i = 0; i < 5; i++) begin
         cyc;
         m_axi.RVALID = 1'b0; s_axi.RREADY = 2'b10;
         @(negedge ap_clk);
         chk("t3_hold_rvalid", 64'(s_axi.RVALID), 64'h1);
         chk("t3_hold_rdata", 64'(s_axi.RDATA), 64'hCAFEF00D);
         chk("t3_hold_arready", 64'(s_axi.ARREADY), 64'h0);
      end
      cyc;
      s_axi.RREADY = 2'b01;
      @(negedge ap_clk);
      chk("t3_rvalid_hs", 64'(s_axi.RVALID), 64'h1);

      // Pointer advanced to 1; slave stalls ARREADY while upstream address changes
      cyc;
      s_axi.RREADY = 2'b00; s_axi.ARVALID = 2'b11; s_axi.ARADDR = {8'h40, 8'h30};
      @(negedge ap_clk);
      chk("t4_arready", 64'(s_axi.ARREADY), 64'h2);
      for (int i = 0; i < 3; i++) begin
         cyc;
         s_axi.ARVALID = 2'b00; s_axi.ARADDR = 16'hEEEE; m_axi.ARREADY = 1'b0;
         @(negedge ap_clk);
         chk("t4_stall_m_arvalid", 64'(m_axi.ARVALID), 64'h1);
         chk("t4_stall_m_araddr", 64'(m_axi.ARADDR), 64'h40);
      end
      cyc;
      m_axi.ARREADY = 1'b1;
      @(negedge ap_clk);
      chk("t4_m_araddr_hs", 64'(m_axi.ARADDR), 64'h40);
      cyc;
      m_axi.ARREADY = 1'b0;
      @(negedge ap_clk);
      chk("t4_data_m_rready", 64'(m_axi.RREADY), 64'h1);
      chk("t4_data_m_arvalid", 64'(m_axi.ARVALID), 64'h0);

      // Reset while in DATA, then a late downstream response
      cyc;
      ap_rst = 1'b1;
      cyc;
      ap_rst = 1'b0; m_axi.RVALID = 1'b1; m_axi.RDATA = 32'h12345678; m_axi.RRESP = 2'b00;
      @(negedge ap_clk);
      chk("t5_m_rready", 64'(m_axi.RREADY), 64'h0);
      chk("t5_m_arvalid", 64'(m_axi.ARVALID), 64'h0);
      chk("t5_s_rvalid", 64'(s_axi.RVALID), 64'h0);
      chk("t5_s_arready", 64'(s_axi.ARREADY), 64'h0);
      cyc;
      s_axi.ARVALID = 2'b11; s_axi.ARADDR = {8'h20, 8'h10};
      @(negedge ap_clk);
      chk("t5_ptr_reset_grant", 64'(s_axi.ARREADY), 64'h1);
      chk("t5_s_rvalid_late", 64'(s_axi.RVALID), 64'h0);
      cyc;
      s_axi.ARVALID = 2'b00; m_axi.ARREADY = 1'b1;
      @(negedge ap_clk);
      chk("t5_unsolicited_rready", 64'(m_axi.RREADY), 64'h0);
      cyc;
      m_axi.ARREADY = 1'b0;
      @(negedge ap_clk);
      chk("t5_data_rready", 64'(m_axi.RREADY), 64'h1);
      cyc;
      m_axi.RVALID = 1'b0; s_axi.RREADY = 2'b01;
      @(negedge ap_clk);
      chk("t5_s_rvalid_after", 64'(s_axi.RVALID), 64'h1);
      chk("t5_s_rdata_after", 64'(s_axi.RDATA), 64'h12345678);
`endif
      cyc;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
